maze_memory: RTL and testbench



---
 rtl/maze_pkg.sv | 19 +
 rtl/maze_memory.sv | 62 ++++++
 tb/tb_maze_memory.sv | 139 +++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze grid storage: geometry, coordinate type
// and the default maze image loaded at reset.
package maze_pkg;

  localparam int COORD_W  = 4;
  localparam int MAZE_DIM = 1 << COORD_W;
  localparam int MAZE_CELLS = MAZE_DIM * MAZE_DIM;

  typedef logic [COORD_W-1:0] coord_t;

  // Default reset image: all cells free. Bit index = y*MAZE_DIM + x.
  localparam logic [MAZE_CELLS-1:0] DEFAULT_MAZE = '0;

  // Linear cell index for a (x, y) coordinate pair: row-major, {y, x}.
  function automatic logic [2*COORD_W-1:0] cell_index(input coord_t x, input coord_t y);
    return {y, x};
  endfunction

endpackage

// File: rtl/maze_memory.sv
// One-bit-per-cell storage for the maze grid. Cells are flops so the whole
// grid can be restored to a fixed image by the asynchronous reset. Reads
// are registered (one-cycle latency) and see the pre-write cell contents
// when a read and a write hit the same cell on the same edge.
module maze_memory
  import maze_pkg::*;
#(
  parameter int COORD_W = maze_pkg::COORD_W,
  parameter logic [(1 << (2*COORD_W))-1:0] INIT_MAZE = maze_pkg::DEFAULT_MAZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd,
  input  logic               wr,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  input  logic               data_in,
  output logic               data_out
);

  localparam int NCELLS = 1 << (2*COORD_W);

  logic [NCELLS-1:0]    cells_q;
  logic [NCELLS-1:0]    cells_d;
  logic                 data_q;
  logic                 data_d;
  logic [2*COORD_W-1:0] addr;

  // Row-major linear address: bit index = y*DIM + x.
  assign addr = {y_pos, x_pos};

  // Write decoder: only the addressed cell may change, and only when wr=1.
  always_comb begin
    cells_d = cells_q;
    if (wr) begin
      cells_d[addr] = data_in;
    end
  end

  // Read mux: samples the current (pre-write) cell so a same-address
  // read/write returns the old value; holds the last value when rd=0.
  always_comb begin
    data_d = data_q;
    if (rd) begin
      data_d = cells_q[addr];
    end
  end

  // Grid and read-data registers; reset reloads the maze image and clears data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cells_q <= INIT_MAZE;
      data_q  <= 1'b0;
    end else begin
      cells_q <= cells_d;
      data_q  <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_maze_memory.sv
// Directed bench for maze_memory with a non-trivial reset image.
module tb_maze_memory;

  // Reset image: (0,3)=bit48, (1,0)=bit1, (15,0)=bit15, (0,15)=bit240 are walls.
  localparam logic [255:0] TB_MAZE =
    (256'd1 << 48) | (256'd1 << 1) | (256'd1 << 15) | (256'd1 << 240);

  logic       clk;
  logic       rst;
  logic       rd;
  logic       wr;
  logic [3:0] x_pos;
  logic [3:0] y_pos;
  logic       data_in;
  logic       data_out;

  int n_cmp;
  int n_bad;

  maze_memory #(
    .COORD_W   (4),
    .INIT_MAZE (TB_MAZE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd),
    .wr       (wr),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] x, input logic [3:0] y);
    rd = 1'b1; wr = 1'b0; x_pos = x; y_pos = y;
    tick();
  endtask

  task automatic do_write(input logic [3:0] x, input logic [3:0] y, input logic d);
    rd = 1'b0; wr = 1'b1; x_pos = x; y_pos = y; data_in = d;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    x_pos = '0; y_pos = '0; data_in = 1'b0;

    // Asynchronous reset clears data_out without a clock edge.
    #2 rst = 1'b1;
    #1 check_bit("reset_data_out", data_out, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset image load.
    do_read(4'd0, 4'd0);
    check_bit("init_read_0_0", data_out, 1'b0);
    do_read(4'd0, 4'd3);
    check_bit("init_read_0_3", data_out, 1'b1);

    // Hold with rd=0 while the address changes.
    rd = 1'b0; y_pos = 4'd0;
    tick();
    check_bit("hold_rd0_a", data_out, 1'b1);
    tick();
    check_bit("hold_rd0_b", data_out, 1'b1);

    // Write then read; neighbours unaffected.
    do_write(4'd0, 4'd0, 1'b1);
    check_bit("write_rd0_hold", data_out, 1'b1);
    do_read(4'd2, 4'd0);
    check_bit("read_2_0_free", data_out, 1'b0);
    do_read(4'd0, 4'd0);
    check_bit("read_after_write_0_0", data_out, 1'b1);
    do_read(4'd1, 4'd0);
    check_bit("neighbour_1_0_init", data_out, 1'b1);

    // Read-before-write on the same cell.
    do_read(4'd5, 4'd5);
    check_bit("pre_rbw_5_5", data_out, 1'b0);
    rd = 1'b1; wr = 1'b1; x_pos = 4'd5; y_pos = 4'd5; data_in = 1'b1;
    tick();
    check_bit("rbw_old_value", data_out, 1'b0);
    wr = 1'b0;
    tick();
    check_bit("rbw_new_value", data_out, 1'b1);

    // Asynchronous reset between edges restores the image.
    rd = 1'b0;
    #3 rst = 1'b1;
    #1 check_bit("midrun_reset_data_out", data_out, 1'b0);
    #1 rst = 1'b0;
    do_read(4'd0, 4'd0);
    check_bit("post_reset_0_0", data_out, 1'b0);
    do_read(4'd5, 4'd5);
    check_bit("post_reset_5_5", data_out, 1'b0);
    do_read(4'd0, 4'd3);
    check_bit("post_reset_0_3", data_out, 1'b1);

    // Corner sweep and aliasing.
    do_write(4'd15, 4'd15, 1'b1);
    do_write(4'd15, 4'd0, 1'b0);
    do_read(4'd15, 4'd15);
    check_bit("corner_15_15", data_out, 1'b1);
    do_read(4'd15, 4'd0);
    check_bit("corner_15_0", data_out, 1'b0);
    do_read(4'd0, 4'd15);
    check_bit("corner_0_15", data_out, 1'b1);
    do_read(4'd0, 4'd0);
    check_bit("corner_0_0", data_out, 1'b0);
    do_read(4'd15, 4'd14);
    check_bit("corner_15_14", data_out, 1'b0);

    rd = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
